// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and widths for the memory request arbiter.
package mem_arb_pkg;
   localparam int LINE_W = 512;
   localparam int ADDR_W = 64;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
   typedef enum logic {IC, DC} req_id_e;
endpackage

// File: rtl/mem_req_arb_if.sv
// mem_req_arb_if: icache, dcache and bus-interface handshakes of the arbiter.
interface mem_req_arb_if;
   import mem_arb_pkg::*;
   logic              ic_req_vld_i;
   logic              ic_req_ack_o;
   logic [ADDR_W-1:0] ic_req_addr_i;
   logic              ic_resp_vld_o;
   logic              ic_resp_ack_i;
   logic              dc_req_vld_i;
   logic              dc_req_ack_o;
   logic              dc_req_rd_i;
   logic [ADDR_W-1:0] dc_req_addr_i;
   logic [LINE_W-1:0] dc_req_wdata_i;
   logic              dc_resp_vld_o;
   logic              dc_resp_ack_i;
   logic [LINE_W-1:0] resp_rdata_o;
   logic              resp_err_o;
   logic              biu_req_vld_o;
   logic              biu_req_ack_i;
   logic              biu_req_rd_o;
   logic [ADDR_W-1:0] biu_req_addr_o;
   logic [LINE_W-1:0] biu_req_wdata_o;
   logic              biu_resp_vld_i;
   logic              biu_resp_ack_o;
   logic [LINE_W-1:0] biu_resp_rdata_i;
   logic              biu_resp_err_i;
   modport slave (
      input  ic_req_vld_i, ic_req_addr_i, ic_resp_ack_i,
      input  dc_req_vld_i, dc_req_rd_i, dc_req_addr_i, dc_req_wdata_i, dc_resp_ack_i,
      input  biu_req_ack_i, biu_resp_vld_i, biu_resp_rdata_i, biu_resp_err_i,
      output ic_req_ack_o, ic_resp_vld_o, dc_req_ack_o, dc_resp_vld_o, resp_rdata_o, resp_err_o,
      output biu_req_vld_o, biu_req_rd_o, biu_req_addr_o, biu_req_wdata_o, biu_resp_ack_o
   );
   modport master (
      output ic_req_vld_i, ic_req_addr_i, ic_resp_ack_i,
      output dc_req_vld_i, dc_req_rd_i, dc_req_addr_i, dc_req_wdata_i, dc_resp_ack_i,
      output biu_req_ack_i, biu_resp_vld_i, biu_resp_rdata_i, biu_resp_err_i,
      input  ic_req_ack_o, ic_resp_vld_o, dc_req_ack_o, dc_resp_vld_o, resp_rdata_o, resp_err_o,
      input  biu_req_vld_o, biu_req_rd_o, biu_req_addr_o, biu_req_wdata_o, biu_resp_ack_o
   );
endinterface

// File: rtl/mem_arb_rr2.sv
// mem_arb_rr2: two-way round-robin grant; the last-granted requester loses priority.
module mem_arb_rr2
   import mem_arb_pkg::*;
(
   input  logic    clk,
   input  logic    rst_n,
   input  logic    en,
   input  logic    req_ic,
   input  logic    req_dc,
   output logic    gnt_vld,
   output req_id_e gnt_id
);
   req_id_e prio_q, prio_d;
   always_comb begin
      gnt_vld = en & (req_ic | req_dc);
      gnt_id = (req_dc & ((prio_q == DC) | ~req_ic)) ? DC : IC;
      prio_d = !gnt_vld ? prio_q : (gnt_id == DC) ? IC : DC;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) prio_q <= DC;
      else prio_q <= prio_d;
endmodule

// File: rtl/mem_req_arb.sv
// mem_req_arb: single-outstanding icache/dcache line arbiter onto the bus interface.
// Define MEM_REQ_ARB_TIMEOUT_EN for the response timeout and late-response drop.
module mem_req_arb
   import mem_arb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input logic          clk,
   input logic          rst_n,
   mem_req_arb_if.slave bus
);
   state_e state_q, state_d;
   req_id_e owner_q, owner_d, gnt_id;
   logic rd_q, rd_d, err_q, err_d, gnt_vld, en, take, drop, tmo;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LINE_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be positive");
   end

`ifdef MEM_REQ_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic drop_q, drop_d;
   assign drop = drop_q & bus.biu_resp_vld_i;
   assign tmo = cnt_q == CW'(TIMEOUT_CYCLES - 1);
   always_comb begin
      cnt_d = (state_q == WAIT) ? cnt_q + 1'b1 : '0;
      drop_d = (state_q == WAIT & tmo & ~take) ? 1'b1 : drop ? 1'b0 : drop_q;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt_q <= '0;
         drop_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         drop_q <= drop_d;
      end
`else
   assign drop = 1'b0;
   assign tmo = 1'b0;
`endif

   // Granting is held off while a stale response is being discarded.
   assign en = rst_n & (state_q == IDLE) & ~drop;
   assign take = (state_q == WAIT) & bus.biu_resp_vld_i & ~drop;

   mem_arb_rr2 u_rr (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .req_ic (bus.ic_req_vld_i),
      .req_dc (bus.dc_req_vld_i),
      .gnt_vld(gnt_vld),
      .gnt_id (gnt_id)
   );

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      rd_d = rd_q;
      addr_d = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d = err_q;
      case (state_q)
         IDLE: if (gnt_vld) begin
            state_d = ISSUE;
            owner_d = gnt_id;
            rd_d = (gnt_id == IC) | bus.dc_req_rd_i;
            addr_d = ((gnt_id == IC) ? bus.ic_req_addr_i : bus.dc_req_addr_i) & ~ADDR_W'(63);
            wdata_d = (gnt_id == IC) ? '0 : bus.dc_req_wdata_i;
         end
         ISSUE: if (bus.biu_req_ack_i) state_d = rd_q ? WAIT : IDLE;
         WAIT: if (take | tmo) begin
            state_d = RESP;
            rdata_d = take ? bus.biu_resp_rdata_i : '0;
            err_d = take ? bus.biu_resp_err_i : 1'b1;
         end
         RESP: if ((owner_q == IC) ? bus.ic_resp_ack_i : bus.dc_resp_ack_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         owner_q <= IC;
         rd_q <= 1'b0;
         addr_q <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         rd_q <= rd_d;
         addr_q <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q <= err_d;
      end

   assign bus.ic_req_ack_o = gnt_vld & (gnt_id == IC);
   assign bus.dc_req_ack_o = gnt_vld & (gnt_id == DC);
   assign bus.biu_req_vld_o = state_q == ISSUE;
   assign bus.biu_req_rd_o = rd_q;
   assign bus.biu_req_addr_o = addr_q;
   assign bus.biu_req_wdata_o = wdata_q;
   assign bus.biu_resp_ack_o = (state_q == WAIT) | drop;
   assign bus.ic_resp_vld_o = (state_q == RESP) & (owner_q == IC);
   assign bus.dc_resp_vld_o = (state_q == RESP) & (owner_q == DC);
   assign bus.resp_rdata_o = rdata_q;
   assign bus.resp_err_o = err_q;
endmodule
